// File: rtl/crypto_stream_pkg.sv
// Shared types and sizing helpers for the block/lane streaming blocks.
package crypto_stream_pkg;

  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_LANE_W  = 8;

  function automatic int lanes_of(input int block_w, input int lane_w);
    return block_w / lane_w;
  endfunction

  function automatic int cnt_w_of(input int block_w, input int lane_w);
    return $clog2(block_w / lane_w);
  endfunction

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } lane_order_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/block_lane_serializer_lane_select.sv
// Combinational lane mux: returns lane idx_i of a block, lane 0 being the LSBs.
module lane_select #(
  parameter int BLOCK_W = 128,
  parameter int LANE_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [CNT_W-1:0]   idx_i,
  output logic [LANE_W-1:0]  lane_o
);

  localparam int N_LANES = BLOCK_W / LANE_W;

  always_comb begin
    lane_o = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (idx_i == CNT_W'(i)) lane_o = block_i[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/block_lane_serializer.sv
// Serialises one BLOCK_W-bit block into LANE_W-bit lanes, LSB- or MSB-lane first.
// in_ready depends combinationally on out_ready and abort so blocks chain without a bubble.
module block_lane_serializer
  import crypto_stream_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int LANE_W  = DEF_LANE_W,
  parameter int CNT_W   = cnt_w_of(BLOCK_W, LANE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_msb_first,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANE_W-1:0]  out_data,
  output logic [CNT_W-1:0]   out_idx,
  output logic               out_last
);

  localparam int               N_LANES  = lanes_of(BLOCK_W, LANE_W);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(N_LANES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    pos_q, pos_d;
  logic [BLOCK_W-1:0]  held_q, held_d;
  lane_order_t         order_q, order_d;

  logic                accept;
  logic                lane_last;
  logic [CNT_W-1:0]    lane_k;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      held_q  <= '0;
      order_q <= ORDER_LSB_FIRST;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      held_q  <= held_d;
      order_q <= order_d;
    end
  end

  // Abort wins over completion and accept; the lane on the bus is not counted as consumed.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    held_d  = held_q;
    order_d = order_q;
    if (abort) begin
      state_d = IDLE;
      pos_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SEND;
            pos_d   = '0;
            held_d  = in_data;
            order_d = lane_order_t'(in_msb_first);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (lane_last) begin
              if (accept) begin
                state_d = SEND;
                pos_d   = '0;
                held_d  = in_data;
                order_d = lane_order_t'(in_msb_first);
              end else begin
                state_d = IDLE;
                pos_d   = '0;
              end
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // out_idx reports the lane number, not the emission position.
  always_comb begin
    lane_last = (state_q == SEND) && (pos_q == LAST_POS);
    lane_k    = (order_q == ORDER_MSB_FIRST) ? (LAST_POS - pos_q) : pos_q;
    out_valid = (state_q == SEND);
    out_last  = lane_last;
    out_idx   = lane_k;
    if (rst || abort)         in_ready = 1'b0;
    else if (state_q == IDLE) in_ready = 1'b1;
    else                      in_ready = lane_last && out_ready;
  end

  lane_select #(
    .BLOCK_W (BLOCK_W),
    .LANE_W  (LANE_W),
    .CNT_W   (CNT_W)
  ) u_lane_select (
    .block_i (held_q),
    .idx_i   (lane_k),
    .lane_o  (out_data)
  );

endmodule

// File: tb/tb_block_lane_serializer.sv
// Directed bench for block_lane_serializer: byte-lane instance plus a 32-bit-lane instance.
module tb_block_lane_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_msb_first, abort;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [7:0]   out_data;
  logic [3:0]   out_idx;

  logic         b_in_valid, b_in_ready, b_in_msb_first, b_abort;
  logic [127:0] b_in_data;
  logic         b_out_valid, b_out_ready, b_out_last;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_idx;

  logic [127:0] blk_a, blk_b;
  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  block_lane_serializer #(.BLOCK_W(128), .LANE_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_msb_first(in_msb_first), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  block_lane_serializer #(.BLOCK_W(128), .LANE_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_msb_first(b_in_msb_first), .abort(b_abort),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last)
  );

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_data = '0; in_msb_first = 0; abort = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_in_msb_first = 0; b_abort = 0; b_out_ready = 0;
    repeat (2) @(negedge clk);
    in_valid = 1;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vec++; if (out_last !== 1'b0) begin errs++; $display("FAIL rst_out_last got %b exp 0", out_last); end
    vec++; if (out_idx !== 4'd0) begin errs++; $display("FAIL rst_out_idx got %0d exp 0", out_idx); end
    vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL rst_out_data got %h exp 00", out_data); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    rst = 1'b0; in_valid = 0;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
    vec++; if (b_in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_b_in_ready got %b exp 1", b_in_ready); end
  endtask

  task automatic test_lsb_first();
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 0; out_ready = 1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lsb_accept_ready got %b exp 1", in_ready); end
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL lsb_valid p=%0d got %b exp 1", p, out_valid); end
      vec++; if (out_data !== 8'(p)) begin errs++; $display("FAIL lsb_data p=%0d got %h exp %h", p, out_data, 8'(p)); end
      vec++; if (out_idx !== 4'(p)) begin errs++; $display("FAIL lsb_idx p=%0d got %0d exp %0d", p, out_idx, p); end
      vec++; if (out_last !== (p == 15)) begin errs++; $display("FAIL lsb_last p=%0d got %b exp %b", p, out_last, p == 15); end
      vec++; if (in_ready !== (p == 15)) begin errs++; $display("FAIL lsb_in_ready p=%0d got %b exp %b", p, in_ready, p == 15); end
    end
    @(negedge clk); #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lsb_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_msb_first();
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 1; out_ready = 1;
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      in_valid = 0;
      if (p == 3) in_msb_first = 0;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL msb_valid p=%0d got %b exp 1", p, out_valid); end
      vec++; if (out_data !== 8'(15 - p)) begin errs++; $display("FAIL msb_data p=%0d got %h exp %h", p, out_data, 8'(15 - p)); end
      vec++; if (out_idx !== 4'(15 - p)) begin errs++; $display("FAIL msb_idx p=%0d got %0d exp %0d", p, out_idx, 15 - p); end
      vec++; if (out_last !== (p == 15)) begin errs++; $display("FAIL msb_last p=%0d got %b exp %b", p, out_last, p == 15); end
    end
    @(negedge clk); #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL msb_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int ep, cyc, stall;
    ep = 0; cyc = 0; stall = 0;
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 0; out_ready = 1;
    while (ep < 16 && cyc < 40) begin
      @(negedge clk);
      in_valid = 0;
      out_ready = !(ep == 5 && stall < 3);
      if (!out_ready) stall++;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid cyc=%0d got %b exp 1", cyc, out_valid); end
      vec++; if (out_data !== 8'(ep)) begin errs++; $display("FAIL bp_data cyc=%0d got %h exp %h", cyc, out_data, 8'(ep)); end
      vec++; if (out_idx !== 4'(ep)) begin errs++; $display("FAIL bp_idx cyc=%0d got %0d exp %0d", cyc, out_idx, ep); end
      vec++; if (out_last !== (ep == 15)) begin errs++; $display("FAIL bp_last cyc=%0d got %b exp %b", cyc, out_last, ep == 15); end
      if (out_ready) ep++;
      cyc++;
    end
    vec++; if (cyc != 19) begin errs++; $display("FAIL bp_cycles got %0d exp 19", cyc); end
    @(negedge clk);
    out_ready = 1;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic [3:0] exp_k;
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 0; out_ready = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 0) begin in_data = blk_b; in_msb_first = 1; end
      if (i == 16) in_valid = 0;
      #1;
      if (i < 16) begin exp_d = 8'(i); exp_k = 4'(i); end
      else begin exp_d = 8'(8'h1F - (i - 16)); exp_k = 4'(31 - i); end
      vec++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid i=%0d got %b exp 1", i, out_valid); end
      vec++; if (out_data !== exp_d) begin errs++; $display("FAIL b2b_data i=%0d got %h exp %h", i, out_data, exp_d); end
      vec++; if (out_idx !== exp_k) begin errs++; $display("FAIL b2b_idx i=%0d got %0d exp %0d", i, out_idx, exp_k); end
      vec++; if (in_ready !== (i == 15 || i == 31)) begin errs++; $display("FAIL b2b_in_ready i=%0d got %b exp %b", i, in_ready, i == 15 || i == 31); end
    end
    @(negedge clk); #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 0; out_ready = 1;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      vec++; if (out_data !== 8'(p)) begin errs++; $display("FAIL abort_pre_data p=%0d got %h exp %h", p, out_data, 8'(p)); end
    end
    @(negedge clk);
    abort = 1; in_valid = 1; in_data = blk_b; in_msb_first = 1;
    #1;
    vec++; if (out_data !== 8'h05) begin errs++; $display("FAIL abort_lane got %h exp 05", out_data); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    abort = 0;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_valid_drop got %b exp 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL abort_idle_ready got %b exp 1", in_ready); end
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      vec++; if (out_data !== 8'(8'h1F - p)) begin errs++; $display("FAIL abort_next_data p=%0d got %h exp %h", p, out_data, 8'(8'h1F - p)); end
      vec++; if (out_idx !== 4'(15 - p)) begin errs++; $display("FAIL abort_next_idx p=%0d got %0d exp %0d", p, out_idx, 15 - p); end
    end
    @(negedge clk);
    abort = 1; in_valid = 1; in_data = blk_a; in_msb_first = 0;
    #1;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL abort_idle_mask got %b exp 0", in_ready); end
    @(negedge clk);
    abort = 0; in_valid = 0;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_idle_noaccept got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_block();
    @(negedge clk);
    in_valid = 1; in_data = blk_a; in_msb_first = 0; out_ready = 1;
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      vec++; if (out_data !== 8'(p)) begin errs++; $display("FAIL rstmid_pre_data p=%0d got %h exp %h", p, out_data, 8'(p)); end
    end
    #2;
    rst = 1; in_valid = 1;
    #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
    vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL rstmid_data got %h exp 00", out_data); end
    @(negedge clk);
    rst = 0;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rstmid_release_ready got %b exp 1", in_ready); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_release_valid got %b exp 0", out_valid); end
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      in_valid = 0;
      #1;
      vec++; if (out_data !== 8'(p) || out_idx !== 4'(p)) begin errs++; $display("FAIL rstmid_after p=%0d got %h/%0d exp %h/%0d", p, out_data, out_idx, 8'(p), p); end
    end
    @(negedge clk); #1;
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rstmid_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_lane32();
    logic [31:0] exp_l;
    @(negedge clk);
    b_in_valid = 1; b_in_data = 128'h33333333_22222222_11111111_00000000;
    b_in_msb_first = 0; b_out_ready = 1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      b_in_valid = 0;
      #1;
      exp_l = 32'h11111111 * 32'(p);
      vec++; if (b_out_valid !== 1'b1) begin errs++; $display("FAIL l32_valid p=%0d got %b exp 1", p, b_out_valid); end
      vec++; if (b_out_data !== exp_l) begin errs++; $display("FAIL l32_data p=%0d got %h exp %h", p, b_out_data, exp_l); end
      vec++; if (b_out_idx !== 2'(p)) begin errs++; $display("FAIL l32_idx p=%0d got %0d exp %0d", p, b_out_idx, p); end
      vec++; if (b_out_last !== (p == 3)) begin errs++; $display("FAIL l32_last p=%0d got %b exp %b", p, b_out_last, p == 3); end
    end
    @(negedge clk); #1;
    vec++; if (b_out_valid !== 1'b0) begin errs++; $display("FAIL l32_idle got %b exp 0", b_out_valid); end
  endtask

  initial begin
    blk_a = 128'h0F0E0D0C0B0A09080706050403020100;
    for (int k = 0; k < 16; k++) blk_b[k*8 +: 8] = 8'(16 + k);
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid_block();
    test_lane32();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
